// File: rtl/row_clear.sv
`default_nettype none
// ============================================================================
//  Module      : row_clear
//  Description : Line-clear engine for a falling-block game board.
//                After a piece locks, a start pulse snapshots the board.
//                The engine walks it bottom-up, removes every full row by
//                shifting the rows above it down one place, and reports the
//                compacted board, the number of rows removed and a running
//                score.
//
//  Ports       : Clk           - game clock, rising edge active
//                Reset         - synchronous active-high reset
//                start         - one-cycle scan request (ignored while busy)
//                board_in      - flattened board, row r at [r*COLS +: COLS],
//                                row 0 is the top row
//                board_out     - compacted board, same packing as board_in
//                busy          - high from the accepted start to done inclusive
//                done          - one-cycle pulse, results valid in this cycle
//                lines_cleared - rows removed by the last scan
//                score         - accumulated score, saturates at 16'hFFFF
//
//  Config      : ROW_CLEAR_BONUS_EN defined   -> increment 1,3,5,8 for 1..4
//                                                rows, 2*n above four rows
//                ROW_CLEAR_BONUS_EN undefined -> increment equals rows cleared
//
//  Revision    : 1.0  initial release
// ============================================================================
module row_clear #(
    parameter int ROWS = 12,
    parameter int COLS = 10
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 start,
    input  logic [ROWS*COLS-1:0] board_in,
    output logic [ROWS*COLS-1:0] board_out,
    output logic                 busy,
    output logic                 done,
    output logic [3:0]           lines_cleared,
    output logic [15:0]          score
);

    localparam logic [1:0]      c_st_idle  = 2'd0;
    localparam logic [1:0]      c_st_scan  = 2'd1;
    localparam logic [1:0]      c_st_shift = 2'd2;
    localparam logic [1:0]      c_st_done  = 2'd3;
    localparam logic [3:0]      c_last_row = 4'(ROWS - 1);
    localparam logic [COLS-1:0] c_full_row = '1;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [3:0]           r_row;
    logic [3:0]           r_cnt;
    logic [3:0]           r_lines;
    logic [15:0]          r_score;
    logic [ROWS*COLS-1:0] r_work;
    logic [ROWS*COLS-1:0] r_board_out;

    logic [COLS-1:0]      w_cur_row;
    logic [COLS-1:0]      w_in_row;
    logic                 w_cur_full;
    logic                 w_in_full;
    logic [ROWS*COLS-1:0] w_shifted;
    logic [3:0]           w_cnt_inc;
    logic [ROWS*COLS-1:0] w_fin_board;
    logic [3:0]           w_fin_cnt;
    logic [15:0]          w_inc;
    logic [16:0]          w_score_sum;
    logic [15:0]          w_score_nxt;
    logic                 w_to_done;

    // Row under examination, and the row that a shift would drop into it.
    // Above row 0 nothing exists, so an empty row falls in.
    always_comb begin
        w_cur_row = r_work[int'(r_row)*COLS +: COLS];
        w_in_row  = '0;
        if (r_row != 4'd0) begin
            w_in_row = r_work[(int'(r_row) - 1)*COLS +: COLS];
        end
        w_cur_full = (w_cur_row == c_full_row);
        w_in_full  = (w_in_row == c_full_row);
    end

    // Rows 1..r take the row above, row 0 empties, rows below r are untouched.
    always_comb begin
        w_shifted = r_work;
        w_shifted[COLS-1:0] = '0;
        for (int i = 1; i < ROWS; i++) begin
            if (i <= int'(r_row)) begin
                w_shifted[i*COLS +: COLS] = r_work[(i-1)*COLS +: COLS];
            end
        end
    end

    assign w_cnt_inc = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;

    // The shift cycle also judges the row it moves into position r, so each
    // cleared row costs exactly one extra cycle. Results are captured on the
    // edge that enters DONE so they are valid while done is high; when that
    // edge leaves a shift, the freshly shifted board and count are used.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            c_st_idle: begin
                if (start) w_state_nxt = c_st_scan;
            end
            c_st_scan: begin
                if (w_cur_full)            w_state_nxt = c_st_shift;
                else if (r_row == 4'd0)    w_state_nxt = c_st_done;
            end
            c_st_shift: begin
                if (w_in_full)             w_state_nxt = c_st_shift;
                else if (r_row == 4'd0)    w_state_nxt = c_st_done;
                else                       w_state_nxt = c_st_scan;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    assign w_to_done   = (w_state_nxt == c_st_done) && (r_state != c_st_done);
    assign w_fin_board = (r_state == c_st_shift) ? w_shifted : r_work;
    assign w_fin_cnt   = (r_state == c_st_shift) ? w_cnt_inc : r_cnt;

    always_comb begin
`ifdef ROW_CLEAR_BONUS_EN
        unique case (w_fin_cnt)
            4'd0:    w_inc = 16'd0;
            4'd1:    w_inc = 16'd1;
            4'd2:    w_inc = 16'd3;
            4'd3:    w_inc = 16'd5;
            4'd4:    w_inc = 16'd8;
            default: w_inc = {11'd0, w_fin_cnt, 1'b0};
        endcase
`else
        w_inc = {12'd0, w_fin_cnt};
`endif
        w_score_sum = {1'b0, r_score} + {1'b0, w_inc};
        w_score_nxt = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
    end

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= c_st_idle;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_row       <= c_last_row;
            r_cnt       <= 4'd0;
            r_work      <= '0;
            r_board_out <= '0;
            r_lines     <= 4'd0;
            r_score     <= 16'd0;
        end else begin
            unique case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_work <= board_in;
                        r_row  <= c_last_row;
                        r_cnt  <= 4'd0;
                    end
                end
                c_st_scan: begin
                    if (!w_cur_full && r_row != 4'd0) r_row <= r_row - 4'd1;
                end
                c_st_shift: begin
                    r_work <= w_shifted;
                    r_cnt  <= w_cnt_inc;
                    if (!w_in_full && r_row != 4'd0) r_row <= r_row - 4'd1;
                end
                default: ;
            endcase
            if (w_to_done) begin
                r_board_out <= w_fin_board;
                r_lines     <= w_fin_cnt;
                r_score     <= w_score_nxt;
            end
        end
    end

    assign board_out     = r_board_out;
    assign lines_cleared = r_lines;
    assign score         = r_score;
    assign busy          = (r_state != c_st_idle);
    assign done          = (r_state == c_st_done);

endmodule
`default_nettype wire

// File: tb/tb_row_clear.sv
`default_nettype none
// ============================================================================
//  Module      : tb_row_clear
//  Description : Self-checking bench for row_clear (ROWS=12, COLS=10).
//                Table of directed boards with hand-computed results, then
//                hand-written sequences for restart-while-busy, mid-scan
//                reset and score saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_row_clear;

    localparam int ROWS = 12;
    localparam int COLS = 10;
    localparam int NB   = ROWS * COLS;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          start;
    logic [NB-1:0] board_in;
    logic [NB-1:0] board_out;
    logic          busy;
    logic          done;
    logic [3:0]    lines_cleared;
    logic [15:0]   score;

    row_clear #(.ROWS(ROWS), .COLS(COLS)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .start         (start),
        .board_in      (board_in),
        .board_out     (board_out),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared),
        .score         (score)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [NB-1:0] brd;
        logic [NB-1:0] exp_brd;
        logic [3:0]    exp_lines;
        int            exp_cyc;
        logic [15:0]   sc_plain;
        logic [15:0]   sc_bonus;
    } vec_t;

    vec_t v[6];
    int   n_chk  = 0;
    int   n_pass = 0;

`ifdef ROW_CLEAR_BONUS_EN
    localparam bit BONUS = 1'b1;
`else
    localparam bit BONUS = 1'b0;
`endif

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [NB-1:0] set_row(input logic [NB-1:0] b, input int r,
                                              input logic [COLS-1:0] val);
        logic [NB-1:0] t;
        t = b;
        t[r*COLS +: COLS] = val;
        return t;
    endfunction

    // Pulses start, then returns the cycle number (1 = first cycle after the
    // accepting edge) in which done is seen, or 0 on timeout. A second start
    // pulse is driven in cycle restart_at when nonzero.
    task automatic run_scan(input logic [NB-1:0] brd, input int restart_at, output int cyc);
        @(negedge Clk);
        board_in = brd;
        start    = 1'b1;
        @(posedge Clk);
        cyc = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge Clk);
            if (k == 1) start = 1'b0;
            if (k == restart_at) start = 1'b1;
            if (restart_at != 0 && k == restart_at + 1) start = 1'b0;
            if (done) begin
                cyc = k;
                break;
            end
        end
        start = 1'b0;
        if (cyc == 0) $display("FAIL scan_timeout: got no done expected done within 60 cycles");
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int            cyc;
        int            seen;
        logic [NB-1:0] b;
        logic [15:0]   exp_sc;

        // ---------------- vector table ----------------
        v[0].brd = '0; v[0].exp_brd = '0; v[0].exp_lines = 4'd0; v[0].exp_cyc = 13;
        v[0].sc_plain = 16'd0;  v[0].sc_bonus = 16'd0;

        b = set_row('0, 11, 10'h3FF); b = set_row(b, 10, 10'h001);
        v[1].brd = b; v[1].exp_brd = set_row('0, 11, 10'h001); v[1].exp_lines = 4'd1;
        v[1].exp_cyc = 14; v[1].sc_plain = 16'd1; v[1].sc_bonus = 16'd1;

        b = '0;
        for (int r = 8; r < 12; r++) b = set_row(b, r, 10'h3FF);
        b = set_row(b, 7, 10'h155);
        v[2].brd = b; v[2].exp_brd = set_row('0, 11, 10'h155); v[2].exp_lines = 4'd4;
        v[2].exp_cyc = 17; v[2].sc_plain = 16'd5; v[2].sc_bonus = 16'd9;

        b = set_row('0, 0, 10'h3FF); b = set_row(b, 5, 10'h2AA);
        v[3].brd = b; v[3].exp_brd = set_row('0, 5, 10'h2AA); v[3].exp_lines = 4'd1;
        v[3].exp_cyc = 14; v[3].sc_plain = 16'd6; v[3].sc_bonus = 16'd10;

        b = '0;
        for (int r = 0; r < 12; r++) b = set_row(b, r, 10'h3FF);
        v[4].brd = b; v[4].exp_brd = '0; v[4].exp_lines = 4'd12;
        v[4].exp_cyc = 25; v[4].sc_plain = 16'd18; v[4].sc_bonus = 16'd34;

        b = set_row('0, 11, 10'h3FF); b = set_row(b, 10, 10'h3FE); b = set_row(b, 6, 10'h3FF);
        b = set_row(b, 3, 10'h0AB);   b = set_row(b, 0, 10'h3FF);
        v[5].brd = b;
        v[5].exp_brd = set_row(set_row('0, 11, 10'h3FE), 5, 10'h0AB);
        v[5].exp_lines = 4'd3; v[5].exp_cyc = 16; v[5].sc_plain = 16'd21; v[5].sc_bonus = 16'd39;

        // ---------------- reset state ----------------
        Reset = 1'b1; start = 1'b0; board_in = '0;
        repeat (2) @(negedge Clk);
        chk("rst_busy",  busy, 1'b0);
        chk("rst_done",  done, 1'b0);
        chk("rst_board", board_out, '0);
        chk("rst_lines", lines_cleared, 4'd0);
        chk("rst_score", score, 16'd0);
        Reset = 1'b0;

        // ---------------- table-driven scans ----------------
        for (int i = 0; i < 6; i++) begin
            run_scan(v[i].brd, 0, cyc);
            chk($sformatf("v%0d_latency", i), cyc, v[i].exp_cyc);
            chk($sformatf("v%0d_busy", i), busy, 1'b1);
            chk($sformatf("v%0d_board", i), board_out, v[i].exp_brd);
            chk($sformatf("v%0d_lines", i), lines_cleared, v[i].exp_lines);
            chk($sformatf("v%0d_score", i), score, BONUS ? v[i].sc_bonus : v[i].sc_plain);
            @(negedge Clk);
            chk($sformatf("v%0d_done_end", i), {busy, done}, 2'b00);
        end

        // Results hold between done pulses.
        board_in = '1;
        repeat (4) @(negedge Clk);
        chk("hold_board", board_out, v[5].exp_brd);
        chk("hold_lines", lines_cleared, v[5].exp_lines);

        // ---------------- non-adjacent rows, start while busy ----------------
        b = set_row('0, 11, 10'h3FF); b = set_row(b, 10, 10'h0F0); b = set_row(b, 9, 10'h3FF);
        run_scan(b, 3, cyc);
        chk("busy_start_latency", cyc, 15);
        chk("nonadj_board", board_out, set_row('0, 11, 10'h0F0));
        chk("nonadj_lines", lines_cleared, 4'd2);
        chk("nonadj_score", score, BONUS ? 16'd42 : 16'd23);
        @(negedge Clk);
        chk("nonadj_idle", {busy, done}, 2'b00);

        // ---------------- reset in the middle of a scan ----------------
        @(negedge Clk);
        board_in = v[1].brd; start = 1'b1;
        @(posedge Clk);
        @(negedge Clk); start = 1'b0;
        repeat (4) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk("midrst_busy",  busy, 1'b0);
        chk("midrst_done",  done, 1'b0);
        chk("midrst_board", board_out, '0);
        chk("midrst_lines", lines_cleared, 4'd0);
        chk("midrst_score", score, 16'd0);
        Reset = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge Clk);
            if (done) seen++;
        end
        chk("midrst_no_done", seen, 0);
        run_scan(v[1].brd, 0, cyc);
        chk("after_rst_latency", cyc, 14);
        chk("after_rst_board", board_out, v[1].exp_brd);
        chk("after_rst_score", score, 16'd1);

        // ---------------- score saturation ----------------
        // Park the accumulator just below the ceiling instead of spending
        // tens of thousands of scans getting there.
        @(negedge Clk);
        force dut.r_score = 16'hFFFE;
        @(negedge Clk);
        release dut.r_score;
        @(negedge Clk);
        chk("sat_preload", score, 16'hFFFE);
        b = set_row('0, 11, 10'h3FF); b = set_row(b, 10, 10'h3FF); b = set_row(b, 9, 10'h003);
        run_scan(b, 0, cyc);
        chk("sat_latency", cyc, 15);
        chk("sat_lines", lines_cleared, 4'd2);
        chk("sat_board", board_out, set_row('0, 11, 10'h003));
        exp_sc = 16'hFFFF;
        chk("sat_score", score, exp_sc);
        run_scan(v[1].brd, 0, cyc);
        chk("sat_nowrap", score, exp_sc);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/row_clear.md
ROW_CLEAR -- requirements
Module: row_clear

Interface
REQ-001 Parameter ROWS, default 12, number of board rows; row 0 is the top row, row ROWS-1 is the bottom row.
REQ-002 Parameter COLS, default 10, number of cells per row.
REQ-003 Clk  input  1  single clock (game clock); all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset, sampled on rising edge of Clk.
REQ-005 start  input  1  one-cycle request to scan the board after a piece locks.
REQ-006 board_in  input  ROWS*COLS  flattened board; row r occupies bits [r*COLS+COLS-1 : r*COLS].
REQ-007 board_out  output  ROWS*COLS  compacted board, same packing as board_in.
REQ-008 busy  output  1  high from accepted start until the done cycle inclusive.
REQ-009 done  output  1  one-cycle pulse; board_out, lines_cleared and score are valid in this cycle.
REQ-010 lines_cleared  output  4  number of rows removed by the last scan.
REQ-011 score  output  16  accumulated score.

Function
REQ-012 The block SHALL implement states IDLE, SCAN, SHIFT, DONE.
REQ-013 IDLE: start=1 SHALL copy board_in to an internal working board, set row index r=ROWS-1, clear the line counter, and enter SCAN on the next edge.
REQ-014 start while busy=1 SHALL be ignored with no effect on state or outputs.
REQ-015 SCAN: each cycle examines working row r; if all COLS bits are 1, the block SHALL enter SHIFT; otherwise r decrements; after evaluating r=0 not full, the block SHALL enter DONE.
REQ-016 SHIFT (one cycle): rows r down to 1 take the contents of row r-1, row 0 becomes all zeros, line counter increments by 1, r is unchanged, and the block SHALL return to SCAN to re-examine row r.
REQ-017 A full row 0 SHALL be handled by SHIFT (row 0 cleared) and then rescanned as empty.
REQ-018 DONE (one cycle): board_out SHALL load the working board, lines_cleared the counter, score the updated value, done=1; next state IDLE.
REQ-019 Latency: done SHALL assert exactly ROWS+1 cycles after the accepting edge plus one cycle per cleared row (13 cycles with no clears at ROWS=12).
REQ-020 Score increment without bonus SHALL equal lines_cleared; score SHALL saturate at 16'hFFFF, never wrap.
REQ-021 Zero cleared rows SHALL still produce a done pulse with lines_cleared=0 and score unchanged.
REQ-022 board_out, lines_cleared and score SHALL hold their values between done pulses.
REQ-023 busy SHALL be 0 in IDLE and 1 in SCAN, SHIFT, DONE.
REQ-024 Line counter SHALL saturate at 15; ROWS SHALL not exceed 15.

Reset
REQ-025 Reset=1 SHALL force IDLE, r=ROWS-1, working board, board_out, lines_cleared and score to 0, and busy=done=0, on the next edge regardless of state.
REQ-026 Reset SHALL take priority over start in the same cycle; an in-progress scan SHALL be abandoned without a done pulse.

Configuration
REQ-027 Macro ROW_CLEAR_BONUS_EN SHALL select scoring.
REQ-028 Defined: increment = 1, 3, 5, 8 for 1, 2, 3, 4 lines; 2*n for n>4; 0 for n=0.
REQ-029 Undefined: increment = n (REQ-020); all other behaviour identical, saturation applies in both.

Verification
REQ-030 Reset, then board all zeros, start pulse -> done 13 cycles later, lines_cleared=0, score=0, board_out all zeros.
REQ-031 Row 11=10'h3FF, row 10=10'h001, others 0 -> done after 14 cycles, lines_cleared=1, row 11 out=10'h001, rows 0-10 zero, score=1.
REQ-032 Rows 8-11 all 10'h3FF, row 7=10'h155 -> lines_cleared=4, row 11 out=10'h155, score=4 without macro, 8 with ROW_CLEAR_BONUS_EN; done after 17 cycles.
REQ-033 Non-adjacent full rows 9 and 11, row 10=10'h0F0 -> row 11 out=10'h0F0, lines_cleared=2; second start pulse asserted while busy ignored.
REQ-034 Preload score to 16'hFFFE via repeated scans, clear 2 rows -> score=16'hFFFF, no wrap.
REQ-035 Reset asserted mid-SCAN -> next cycle busy=0, all outputs 0, no done pulse; subsequent start runs normally.
